exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the 5-stage ARM pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its outputs. It forwards operands, generates the second operand (Val2), runs the ALU, and holds the NZCV status register. It also computes the branch target and registers its results into the EX/MEM boundary, with freeze support for SRAM stalls.

## Interface
- no parameters; data path fixed at 32 bits
- clk  in  1  pipeline clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- SRAM_Freeze  in  1  stall: hold all registered state
- Wb_EN, MEM_R_EN, MEM_W_EN  in  1 each  control bits from ID/EX
- B  in  1  branch taken (condition already resolved upstream)
- S  in  1  update status register
- EXE_CMD  in  4  ALU command
- PC  in  32  address of instruction + 4
- Val_Rn, Val_Rm  in  32 each  register operands
- imm  in  1  Shift_operand is rotate-immediate
- Shift_operand  in  12  immediate/shift field
- Signed_imm_24  in  24  branch offset
- Dest  in  4  destination register
- Sel_src1, Sel_src2  in  2 each  forwarding select: 00 reg, 01 MEM_ALU_Res, 10 WB_Value, 11 reg
- MEM_ALU_Res, WB_Value  in  32 each  forwarded values
- Branch_Taken  out  1  = B, combinational
- Branch_Address  out  32  combinational target
- SR  out  4  registered {N,Z,C,V}; SR[1] feeds ID carry
- EXE_Wb_EN, EXE_MEM_R_EN, EXE_MEM_W_EN  out  1 each  registered control
- EXE_ALU_Res  out  32  registered ALU result / memory address
- EXE_ST_Val  out  32  registered forwarded Rm (store data)
- EXE_Dest  out  4  registered destination

## Operation
- Forwarding: Op1 = mux(Sel_src1) over Val_Rn; Op2 = mux(Sel_src2) over Val_Rm.
- Val2 priority:
  - MEM_R_EN|MEM_W_EN: zero-extended Shift_operand.
  - Else imm: {24'b0,Shift_operand[7:0]} rotated right by 2*Shift_operand[11:8].
  - Else Op2 shifted by Shift_operand[11:7] using type [6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Amount 0 passes Op2 unchanged.
- ALU (33-bit internal sum; C = bit 32):
  - 0001 MOV = Val2; 1001 MVN = ~Val2.
  - 0010 ADD/LDR/STR = Op1+Val2; 0011 ADC = Op1+Val2+C.
  - 0100 SUB/CMP = Op1+~Val2+1; 0101 SBC = Op1+~Val2+C.
  - 0110 AND/TST, 0111 ORR, 1000 EOR.
  - Other codes give 0.
- Flags:
  - N = res[31]; Z = (res==0).
  - Arithmetic: C = carry-out (SUB: 1 = no borrow). V = signed overflow of the effective add.
  - Logical/MOV/MVN: C and V keep the current SR value.
- SR writes at edge when S=1 and SRAM_Freeze=0.
- Branch_Address = PC + {{6{Signed_imm_24[23]}},Signed_imm_24,2'b00}, mod 2^32.
- EX/MEM register captures Wb_EN, MEM_R_EN, MEM_W_EN, ALU result, Op2 and Dest each edge when SRAM_Freeze=0. It holds otherwise.
- No flush input; flushed bubbles arrive with zeroed controls and pass through.

## Timing
- reset_n low: asynchronously, SR=0 and all EXE_* outputs = 0. Release takes effect on the next rising edge.
- Latency: one cycle from ID/EX outputs to EXE_* outputs. SR updates on the same edge. Instruction N+1 sees SR written by N.
- Branch_Taken and Branch_Address are same-cycle combinational (zero latency).
- Freeze and S=1 together: SR not written; EX/MEM holds. On release, the held input instruction is captured exactly once.
- Reset mid-freeze: reset wins.

## Test plan
- ADD Op1=0x7FFFFFFF, Val2 imm 1 (Shift_operand=0x001, imm=1), S=1 -> next edge EXE_ALU_Res=0x80000000, SR=4'b1001.
- SUB 5-5, S=1 -> ALU_Res=0, SR=4'b0110. Follow with AND S=1 result 0x1 -> SR=4'b0010 (C kept, V kept 0).
- imm, Shift_operand=0x4FF -> Val2=0xFF000000 via MOV. Register ROR, Val_Rm=0xF0, Shift_operand=0x260 -> MOV result 0x0000000F.
- Forwarding: Sel_src1=01, MEM_ALU_Res=0x10, Sel_src2=10, WB_Value=0x3, ADD register -> 0x13. STR with Sel_src2=10 -> EXE_ST_Val=0x3.
- Branch: B=1, PC=0x100, Signed_imm_24=0xFFFFFE -> Branch_Taken=1, Branch_Address=0xF8 same cycle.
- SRAM_Freeze high 3 cycles with changing inputs and S=1 -> EXE_* and SR unchanged. reset_n pulse mid-freeze -> all outputs 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM pipeline.
// It forwards the operands, builds Val2 (the shifter operand), runs the ALU and
// holds the NZCV status register. It also resolves the branch target and
// registers its results into the EX/MEM boundary. SRAM_Freeze stalls every
// registered element.
module exe_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SRAM_Freeze,
  input  logic        Wb_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        B,
  input  logic        S,
  input  logic [3:0]  EXE_CMD,
  input  logic [31:0] PC,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  input  logic        imm,
  input  logic [11:0] Shift_operand,
  input  logic [23:0] Signed_imm_24,
  input  logic [3:0]  Dest,
  input  logic [1:0]  Sel_src1,
  input  logic [1:0]  Sel_src2,
  input  logic [31:0] MEM_ALU_Res,
  input  logic [31:0] WB_Value,
  output logic        Branch_Taken,
  output logic [31:0] Branch_Address,
  output logic [3:0]  SR,
  output logic        EXE_Wb_EN,
  output logic        EXE_MEM_R_EN,
  output logic        EXE_MEM_W_EN,
  output logic [31:0] EXE_ALU_Res,
  output logic [31:0] EXE_ST_Val,
  output logic [3:0]  EXE_Dest
);

  logic [31:0] op1, op2, val2, alu_res;
  logic [3:0]  alu_flags;
  logic [63:0] rot_imm_w, ror_reg_w;
  logic [32:0] sum33;
  logic [31:0] addend;
  logic        carry_in, is_arith;

  logic [3:0]  sr_q, sr_d;
  logic        wb_en_q, wb_en_d, mem_r_q, mem_r_d, mem_w_q, mem_w_d;
  logic [31:0] alu_res_q, alu_res_d, st_val_q, st_val_d;
  logic [3:0]  dest_q, dest_d;

  // Forwarding muxes: 01 takes the MEM-stage result, 10 the WB value, 00/11 the register
  always_comb begin
    op1 = Val_Rn;
    op2 = Val_Rm;
    case (Sel_src1)
      2'b01:   op1 = MEM_ALU_Res;
      2'b10:   op1 = WB_Value;
      default: op1 = Val_Rn;
    endcase
    case (Sel_src2)
      2'b01:   op2 = MEM_ALU_Res;
      2'b10:   op2 = WB_Value;
      default: op2 = Val_Rm;
    endcase
  end

  // Val2 generation: the memory offset wins, then the rotated immediate, then the shifted register
  always_comb begin
    // A rotate is the low half of the doubled word shifted right
    rot_imm_w = {24'b0, Shift_operand[7:0], 24'b0, Shift_operand[7:0]} >> {Shift_operand[11:8], 1'b0};
    ror_reg_w = {op2, op2} >> Shift_operand[11:7];
    val2      = op2;
    if (MEM_R_EN || MEM_W_EN) begin
      val2 = {20'b0, Shift_operand};
    end else if (imm) begin
      val2 = rot_imm_w[31:0];
    end else begin
      case (Shift_operand[6:5])
        2'b00:   val2 = op2 << Shift_operand[11:7];
        2'b01:   val2 = op2 >> Shift_operand[11:7];
        2'b10:   val2 = $signed(op2) >>> Shift_operand[11:7];
        default: val2 = ror_reg_w[31:0];
      endcase
    end
  end

  // ALU: subtraction is an add of the inverted operand, so one 33-bit adder covers every arithmetic op
  always_comb begin
    addend   = val2;
    carry_in = 1'b0;
    is_arith = 1'b0;
    alu_res  = 32'b0;
    case (EXE_CMD)
      4'b0010: begin addend = val2;  carry_in = 1'b0;  is_arith = 1'b1; end
      4'b0011: begin addend = val2;  carry_in = sr_q[1]; is_arith = 1'b1; end
      4'b0100: begin addend = ~val2; carry_in = 1'b1;  is_arith = 1'b1; end
      4'b0101: begin addend = ~val2; carry_in = sr_q[1]; is_arith = 1'b1; end
      default: ;
    endcase
    sum33 = {1'b0, op1} + {1'b0, addend} + {32'b0, carry_in};
    case (EXE_CMD)
      4'b0001: alu_res = val2;
      4'b1001: alu_res = ~val2;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: alu_res = sum33[31:0];
      4'b0110: alu_res = op1 & val2;
      4'b0111: alu_res = op1 | val2;
      4'b1000: alu_res = op1 ^ val2;
      default: alu_res = 32'b0;
    endcase
    // C and V come from the effective add; everything else keeps the current C and V
    alu_flags[3] = alu_res[31];
    alu_flags[2] = (alu_res == 32'b0);
    if (is_arith) begin
      alu_flags[1] = sum33[32];
      alu_flags[0] = (op1[31] == addend[31]) && (alu_res[31] != op1[31]);
    end else begin
      alu_flags[1] = sr_q[1];
      alu_flags[0] = sr_q[0];
    end
  end

  // Next-state values: freeze holds everything, S additionally gates the status register
  always_comb begin
    sr_d      = (S && !SRAM_Freeze) ? alu_flags : sr_q;
    wb_en_d   = SRAM_Freeze ? wb_en_q   : Wb_EN;
    mem_r_d   = SRAM_Freeze ? mem_r_q   : MEM_R_EN;
    mem_w_d   = SRAM_Freeze ? mem_w_q   : MEM_W_EN;
    alu_res_d = SRAM_Freeze ? alu_res_q : alu_res;
    st_val_d  = SRAM_Freeze ? st_val_q  : op2;
    dest_d    = SRAM_Freeze ? dest_q    : Dest;
  end

  // Status register and EX/MEM pipeline register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q      <= 4'b0;
      wb_en_q   <= 1'b0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      alu_res_q <= 32'b0;
      st_val_q  <= 32'b0;
      dest_q    <= 4'b0;
    end else begin
      sr_q      <= sr_d;
      wb_en_q   <= wb_en_d;
      mem_r_q   <= mem_r_d;
      mem_w_q   <= mem_w_d;
      alu_res_q <= alu_res_d;
      st_val_q  <= st_val_d;
      dest_q    <= dest_d;
    end
  end

  // The branch condition is resolved upstream; only the target add happens here
  always_comb begin
    Branch_Taken   = B;
    Branch_Address = PC + {{6{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
  end

  assign SR           = sr_q;
  assign EXE_Wb_EN    = wb_en_q;
  assign EXE_MEM_R_EN = mem_r_q;
  assign EXE_MEM_W_EN = mem_w_q;
  assign EXE_ALU_Res  = alu_res_q;
  assign EXE_ST_Val   = st_val_q;
  assign EXE_Dest     = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: a reference model pushes the expected EX/MEM contents into a
// queue when an instruction is driven, and the entry is popped and compared one edge later.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        reset_n, SRAM_Freeze, Wb_EN, MEM_R_EN, MEM_W_EN, B, S, imm;
  logic [3:0]  EXE_CMD, Dest;
  logic [31:0] PC, Val_Rn, Val_Rm, MEM_ALU_Res, WB_Value;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [1:0]  Sel_src1, Sel_src2;
  logic        Branch_Taken;
  logic [31:0] Branch_Address;
  logic [3:0]  SR;
  logic        EXE_Wb_EN, EXE_MEM_R_EN, EXE_MEM_W_EN;
  logic [31:0] EXE_ALU_Res, EXE_ST_Val;
  logic [3:0]  EXE_Dest;

  // expected entry: {wb, mr, mw, alu_res[31:0], st_val[31:0], dest[3:0], sr[3:0]}
  logic [74:0] exp_q[$];
  logic [74:0] last_exp;
  logic [3:0]  sr_m;
  int          total = 0;
  int          bad   = 0;

  exe_stage dut (
    .clk(clk), .reset_n(reset_n), .SRAM_Freeze(SRAM_Freeze),
    .Wb_EN(Wb_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .B(B), .S(S), .EXE_CMD(EXE_CMD), .PC(PC),
    .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm),
    .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
    .Dest(Dest), .Sel_src1(Sel_src1), .Sel_src2(Sel_src2),
    .MEM_ALU_Res(MEM_ALU_Res), .WB_Value(WB_Value),
    .Branch_Taken(Branch_Taken), .Branch_Address(Branch_Address), .SR(SR),
    .EXE_Wb_EN(EXE_Wb_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN), .EXE_MEM_W_EN(EXE_MEM_W_EN),
    .EXE_ALU_Res(EXE_ALU_Res), .EXE_ST_Val(EXE_ST_Val), .EXE_Dest(EXE_Dest)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    for (int i = 0; i < n; i++) x = {x[0], x[31:1]};
    return x;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] reg_v);
    if (sel == 2'b01) return MEM_ALU_Res;
    if (sel == 2'b10) return WB_Value;
    return reg_v;
  endfunction

  function automatic logic [31:0] m_val2(input logic [31:0] op2);
    logic [31:0] x;
    int amt;
    if (MEM_R_EN || MEM_W_EN) return {20'b0, Shift_operand};
    if (imm) return m_rotr({24'b0, Shift_operand[7:0]}, 2 * int'(Shift_operand[11:8]));
    x   = op2;
    amt = int'(Shift_operand[11:7]);
    for (int i = 0; i < amt; i++) begin
      case (Shift_operand[6:5])
        2'b00:   x = {x[30:0], 1'b0};
        2'b01:   x = {1'b0, x[31:1]};
        2'b10:   x = {x[31], x[31:1]};
        default: x = {x[0], x[31:1]};
      endcase
    end
    return x;
  endfunction

  task automatic m_alu(input logic [31:0] a, input logic [31:0] v2, input logic [3:0] sr_in,
                       output logic [31:0] res, output logic [3:0] sr_out);
    logic [31:0] b;
    logic        cin, arith, c, v;
    logic [63:0] s;
    longint      ls;
    b = v2; cin = 1'b0; arith = 1'b1; res = 32'b0;
    case (EXE_CMD)
      4'd2: begin b = v2;  cin = 1'b0; end
      4'd3: begin b = v2;  cin = sr_in[1]; end
      4'd4: begin b = ~v2; cin = 1'b1; end
      4'd5: begin b = ~v2; cin = sr_in[1]; end
      default: arith = 1'b0;
    endcase
    case (EXE_CMD)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd6: res = a & v2;
      4'd7: res = a | v2;
      4'd8: res = a ^ v2;
      default: res = 32'b0;
    endcase
    if (arith) begin
      s   = {32'b0, a} + {32'b0, b} + {63'b0, cin};
      res = s[31:0];
      c   = s[32];
      ls  = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
      v   = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
      sr_out = {res[31], res == 32'b0, c, v};
    end else begin
      sr_out = {res[31], res == 32'b0, sr_in[1:0]};
    end
  endtask

  // ---------------- driver / scoreboard ----------------
  // Inputs are already set; compute expectation, push, clock, pop and compare.
  task automatic step(input string tag);
    logic [31:0] o1, o2, v2, res;
    logic [3:0]  new_sr, sr_next;
    logic [74:0] e, got;
    o1 = m_fwd(Sel_src1, Val_Rn);
    o2 = m_fwd(Sel_src2, Val_Rm);
    v2 = m_val2(o2);
    m_alu(o1, v2, sr_m, res, new_sr);
    sr_next = (S && !SRAM_Freeze) ? new_sr : sr_m;
    if (SRAM_Freeze) e = {last_exp[74:4], sr_next};
    else             e = {Wb_EN, MEM_R_EN, MEM_W_EN, res, o2, Dest, sr_next};
    sr_m = sr_next;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e        = exp_q.pop_front();
    last_exp = e;
    got = {EXE_Wb_EN, EXE_MEM_R_EN, EXE_MEM_W_EN, EXE_ALU_Res, EXE_ST_Val, EXE_Dest, SR};
    check({tag, ".wb"},   {31'b0, got[74]}, {31'b0, e[74]});
    check({tag, ".mr"},   {31'b0, got[73]}, {31'b0, e[73]});
    check({tag, ".mw"},   {31'b0, got[72]}, {31'b0, e[72]});
    check({tag, ".res"},  got[71:40], e[71:40]);
    check({tag, ".st"},   got[39:8],  e[39:8]);
    check({tag, ".dest"}, {28'b0, got[7:4]}, {28'b0, e[7:4]});
    check({tag, ".sr"},   {28'b0, got[3:0]}, {28'b0, e[3:0]});
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic s_v, input logic imm_v,
                        input logic [11:0] so, input logic [31:0] rn, input logic [31:0] rm);
    EXE_CMD = cmd; S = s_v; imm = imm_v; Shift_operand = so; Val_Rn = rn; Val_Rm = rm;
    Sel_src1 = 2'b00; Sel_src2 = 2'b00; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    Wb_EN = 1'b1; Dest = Dest + 4'd1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".sr"},  {28'b0, SR}, 32'h0);
    check({tag, ".res"}, EXE_ALU_Res, 32'h0);
    check({tag, ".st"},  EXE_ST_Val, 32'h0);
    check({tag, ".ctl"}, {24'b0, EXE_Wb_EN, EXE_MEM_R_EN, EXE_MEM_W_EN, 1'b0, EXE_Dest}, 32'h0);
  endtask

  initial begin
    // reset
    reset_n = 1'b0; SRAM_Freeze = 1'b0; Wb_EN = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    B = 1'b0; S = 1'b0; imm = 1'b0; EXE_CMD = 4'd0; PC = 32'h0; Val_Rn = 32'h0; Val_Rm = 32'h0;
    Shift_operand = 12'h0; Signed_imm_24 = 24'h0; Dest = 4'h0; Sel_src1 = 2'b00; Sel_src2 = 2'b00;
    MEM_ALU_Res = 32'h0; WB_Value = 32'h0;
    sr_m = 4'h0; last_exp = '0;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // signed overflow on ADD with rotate-immediate 1
    set_op(4'd2, 1'b1, 1'b1, 12'h001, 32'h7FFF_FFFF, 32'h0);
    step("add_ovf");
    check("add_ovf.res_lit", EXE_ALU_Res, 32'h8000_0000);
    check("add_ovf.sr_lit",  {28'b0, SR}, 32'h9);

    // SUB to zero, then AND keeps C and V
    set_op(4'd4, 1'b1, 1'b0, 12'h000, 32'd5, 32'd5);
    step("sub_zero");
    check("sub_zero.sr_lit", {28'b0, SR}, 32'h6);
    set_op(4'd6, 1'b1, 1'b1, 12'h001, 32'h0000_0003, 32'h0);
    step("and_keep");
    check("and_keep.sr_lit", {28'b0, SR}, 32'h2);

    // ADC / SBC consume the carry from the previous instruction
    set_op(4'd3, 1'b1, 1'b0, 12'h000, 32'hFFFF_FFFF, 32'h1);
    step("adc");
    set_op(4'd5, 1'b1, 1'b0, 12'h000, 32'h10, 32'h20);
    step("sbc");

    // rotate-immediate and register ROR via MOV
    set_op(4'd1, 1'b0, 1'b1, 12'h4FF, 32'h0, 32'h0);
    step("mov_rotimm");
    check("mov_rotimm.lit", EXE_ALU_Res, 32'hFF00_0000);
    set_op(4'd1, 1'b0, 1'b0, 12'h260, 32'h0, 32'hF0);
    step("mov_ror");
    check("mov_ror.lit", EXE_ALU_Res, 32'h0000_000F);
    set_op(4'd9, 1'b1, 1'b0, 12'h0C0, 32'h0, 32'h8000_0000);  // MVN of ASR #1
    step("mvn_asr");

    // forwarding
    set_op(4'd2, 1'b0, 1'b0, 12'h000, 32'hDEAD, 32'hBEEF);
    Sel_src1 = 2'b01; Sel_src2 = 2'b10; MEM_ALU_Res = 32'h10; WB_Value = 32'h3;
    step("fwd_add");
    check("fwd_add.lit", EXE_ALU_Res, 32'h13);
    set_op(4'd2, 1'b0, 1'b0, 12'h008, 32'h100, 32'h777);
    Sel_src2 = 2'b10; MEM_W_EN = 1'b1; Wb_EN = 1'b0;
    step("fwd_str");
    check("fwd_str.st_lit", EXE_ST_Val, 32'h3);

    // branch target is combinational
    B = 1'b1; PC = 32'h100; Signed_imm_24 = 24'hFFFFFE;
    #1;
    check("br.taken", {31'b0, Branch_Taken}, 32'h1);
    check("br.addr",  Branch_Address, 32'hF8);
    Signed_imm_24 = 24'h000010; #1;
    check("br.fwd", Branch_Address, 32'h140);
    B = 1'b0; #1;
    check("br.nt", {31'b0, Branch_Taken}, 32'h0);

    // random instructions
    for (int i = 0; i < 40; i++) begin
      set_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             12'($urandom_range(0, 4095)), $urandom, $urandom);
      Sel_src1 = 2'($urandom_range(0, 3)); Sel_src2 = 2'($urandom_range(0, 3));
      MEM_ALU_Res = $urandom; WB_Value = $urandom;
      MEM_R_EN = ($urandom_range(0, 7) == 0); MEM_W_EN = ($urandom_range(0, 7) == 0);
      Wb_EN = 1'($urandom_range(0, 1));
      step("rnd");
    end

    // freeze for 3 cycles with changing inputs and S=1, then release captures once
    SRAM_Freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_op(4'd4, 1'b1, 1'b0, 12'h000, $urandom, $urandom);
      step("frz");
    end
    set_op(4'd2, 1'b1, 1'b1, 12'h07F, 32'h1000, 32'h0);
    step("frz_last");
    SRAM_Freeze = 1'b0;
    step("frz_rel");
    set_op(4'd7, 1'b1, 1'b1, 12'h0F0, 32'h0F, 32'h0);
    step("post_frz");

    // reset asserted in the middle of a freeze clears everything immediately
    SRAM_Freeze = 1'b1;
    set_op(4'd2, 1'b1, 1'b1, 12'h0AA, 32'h1234, 32'h5678);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_all_zero("rst_frz");
    sr_m = 4'h0; last_exp = '0; exp_q.delete();
    #2 reset_n = 1'b1; SRAM_Freeze = 1'b0;
    @(negedge clk);
    set_op(4'd2, 1'b1, 1'b0, 12'h000, 32'h1, 32'h2);
    step("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
